// File: rtl/ps2_kbd_ctrl_if.sv
// Bundles the PS/2 byte-receiver inputs, the key-event FIFO head, and the status signals
// of the keyboard sequencer. The slave side is the controller; the master side drives it.
interface ps2_kbd_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_error;
  logic       ps2_clk_out;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  logic       key_valid;
  logic       key_ready;
  logic       pause_pulse;
  logic       bat_pulse;
  logic       overflow;
  logic       overflow_clr;

  modport slave (
    input  rx_data, rx_valid, rx_error, key_ready, overflow_clr,
    output ps2_clk_out, key_code, key_ext, key_release, key_valid,
           pause_pulse, bat_pulse, overflow
  );

  modport master (
    output rx_data, rx_valid, rx_error, key_ready, overflow_clr,
    input  ps2_clk_out, key_code, key_ext, key_release, key_valid,
           pause_pulse, bat_pulse, overflow
  );
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// Folds set-2 scancode prefixes (E0/F0/E1) into key events buffered in a FWFT FIFO,
// and inhibits the PS/2 clock for a fixed time after a receive error.
module ps2_kbd_ctrl #(
  parameter int CLK_FREQ   = 28000000,
  parameter int INHIBIT_US = 200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  ps2_kbd_ctrl_if.slave bus
);
  localparam int INHIBIT_TICKS = int'(real'(INHIBIT_US) * real'(CLK_FREQ) / 1.0e6) + 1;
  localparam int TW = $clog2(INHIBIT_TICKS + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [TW-1:0] TICKS_LD = TW'(INHIBIT_TICKS);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXT     = 3'd1,
    S_REL     = 3'd2,
    S_EXTREL  = 3'd3,
    S_PAUSE   = 3'd4,
    S_INHIBIT = 3'd5
  } state_e;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == 8'hE0) || (b == 8'hE1) || (b == 8'hF0);
  endfunction

  state_e          state_q, state_d;
  logic [2:0]      pcnt_q, pcnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            ps2_clk_q, ps2_clk_d;
  logic            pause_q, pause_d;
  logic            bat_q, bat_d;
  logic            ovf_q, ovf_d;
  logic [9:0]      mem_q [FIFO_DEPTH];
  logic [9:0]      mem_d [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [9:0]      head_q, head_d;
  logic            valid_q, valid_d;

  logic            push_s;
  logic [9:0]      push_ent_s;
  logic            pop_s;
  logic            push_ok_s;

  // Decoder FSM: an error outranks any byte; nothing is consumed while inhibiting.
  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    timer_d    = timer_q;
    push_s     = 1'b0;
    push_ent_s = 10'd0;
    pause_d    = 1'b0;
    bat_d      = 1'b0;
    if (state_q == S_INHIBIT) begin
      if (timer_q <= TW'(1)) begin
        state_d = S_IDLE;
        timer_d = {TW{1'b0}};
      end else begin
        timer_d = timer_q - TW'(1);
      end
    end else if (bus.rx_error) begin
      state_d = S_INHIBIT;
      timer_d = TICKS_LD;
      pcnt_d  = 3'd0;
    end else if (bus.rx_valid) begin
      case (state_q)
        S_IDLE: begin
          case (bus.rx_data)
            8'hE0: state_d = S_EXT;
            8'hF0: state_d = S_REL;
            8'hE1: begin
              state_d = S_PAUSE;
              pcnt_d  = 3'd7;
            end
            8'hAA: bat_d = 1'b1;
            8'h00, 8'hFF, 8'hFC: state_d = S_IDLE;
            default: begin
              push_s     = 1'b1;
              push_ent_s = {2'b00, bus.rx_data};
            end
          endcase
        end
        S_EXT: begin
          if (bus.rx_data == 8'hF0) begin
            state_d = S_EXTREL;
          end else if ((bus.rx_data == 8'hE0) || (bus.rx_data == 8'hE1)) begin
            state_d = S_IDLE;
          end else begin
            push_s     = 1'b1;
            push_ent_s = {2'b10, bus.rx_data};
            state_d    = S_IDLE;
          end
        end
        S_REL, S_EXTREL: begin
          state_d = S_IDLE;
          if (is_prefix(bus.rx_data)) begin
            push_s = 1'b0;
          end else begin
            push_s     = 1'b1;
            push_ent_s = {(state_q == S_EXTREL), 1'b1, bus.rx_data};
          end
        end
        S_PAUSE: begin
          if (pcnt_q <= 3'd1) begin
            pause_d = 1'b1;
            pcnt_d  = 3'd0;
            state_d = S_IDLE;
          end else begin
            pcnt_d = pcnt_q - 3'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
    ps2_clk_d = (state_d != S_INHIBIT);
  end

  // Event FIFO: a pop frees the slot a same-cycle push into a full FIFO needs.
  always_comb begin
    pop_s     = bus.key_ready && valid_q;
    push_ok_s = push_s && ((count_q != DEPTH_C) || pop_s);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = push_ent_s;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (push_s && !push_ok_s) begin
      ovf_d = 1'b1;
    end else if (bus.overflow_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    valid_d = (count_d != {CW{1'b0}});
    if (valid_d) begin
      head_d = mem_d[rd_ptr_d];
    end else begin
      head_d = head_q;
    end
  end

  // State, timer, FIFO storage and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pcnt_q    <= 3'd0;
      timer_q   <= {TW{1'b0}};
      ps2_clk_q <= 1'b1;
      pause_q   <= 1'b0;
      bat_q     <= 1'b0;
      ovf_q     <= 1'b0;
      mem_q     <= '{default: 10'd0};
      rd_ptr_q  <= {PW{1'b0}};
      wr_ptr_q  <= {PW{1'b0}};
      count_q   <= {CW{1'b0}};
      head_q    <= 10'd0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      timer_q   <= timer_d;
      ps2_clk_q <= ps2_clk_d;
      pause_q   <= pause_d;
      bat_q     <= bat_d;
      ovf_q     <= ovf_d;
      mem_q     <= mem_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      head_q    <= head_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.ps2_clk_out = ps2_clk_q;
  assign bus.key_code    = head_q[7:0];
  assign bus.key_ext     = head_q[9];
  assign bus.key_release = head_q[8];
  assign bus.key_valid   = valid_q;
  assign bus.pause_pulse = pause_q;
  assign bus.bat_pulse   = bat_q;
  assign bus.overflow    = ovf_q;
endmodule
